// File: rtl/msg_requester.sv
// rtl/msg_requester.sv - UART message initiator: serialise a request, collect the response or time out.
// Optional checksum word in both directions when MSG_REQUESTER_CHECKSUM_EN is defined.
module msg_requester #(
    parameter int WORD_SIZE        = 8,
    parameter int WORDS_PER_PACKET = 4,
    parameter int TIMEOUT_CLKS     = 1_200_000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] req_msg,
    output logic                                  req_ready,
    input  logic                                  uart_tx_ready,
    output logic                                  uart_tx_start,
    output logic [WORD_SIZE-1:0]                  uart_tx_data,
    input  logic                                  uart_rx_valid,
    input  logic [WORD_SIZE-1:0]                  uart_rx_data,
    output logic                                  rsp_valid,
    output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] rsp_msg,
    output logic                                  rsp_timeout,
    output logic                                  rsp_error,
    output logic                                  rx_stray,
    output logic                                  busy
);
    localparam int MSG_W = WORD_SIZE * WORDS_PER_PACKET;
`ifdef MSG_REQUESTER_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int TX_WORDS = WORDS_PER_PACKET + EXTRA;
    localparam int TX_W     = TX_WORDS * WORD_SIZE;
    localparam int CW       = $clog2(TX_WORDS + 1);
    localparam int TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(TX_WORDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, RECV} state_t;

    state_t                    state_q, state_d;
    logic [TX_W-1:0]           tx_shift;
    logic [TX_W-1:0]           tx_load;
    logic [CW-1:0]             word_cnt;
    logic [CW-1:0]             rx_cnt;
    logic [TW-1:0]             timer;
    logic                      tx_seen;
    logic [TX_W-WORD_SIZE-1:0] rx_hist;
    logic [TX_W-1:0]           rx_next;
    logic                      accept, do_start, tx_done, rx_take, rx_done, expire;

`ifdef MSG_REQUESTER_CHECKSUM_EN
    function automatic logic [WORD_SIZE-1:0] xor_words(input logic [MSG_W-1:0] m);
        logic [WORD_SIZE-1:0] acc;
        acc = '0;
        for (int i = 0; i < WORDS_PER_PACKET; i++) acc = acc ^ m[i*WORD_SIZE +: WORD_SIZE];
        return acc;
    endfunction
    logic rsp_error_q;
    assign tx_load   = {req_msg, xor_words(req_msg)};
    assign rsp_error = rsp_error_q;
`else
    assign tx_load   = req_msg;
    assign rsp_error = 1'b0;
`endif

    // Incoming bytes enter at the LSB end, so the first byte received ends up in the MSB word.
    assign rx_next   = {rx_hist, uart_rx_data};
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        do_start = 1'b0;
        tx_done  = 1'b0;
        rx_take  = 1'b0;
        rx_done  = 1'b0;
        expire   = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = SEND;
            end
            SEND: if (uart_tx_ready) begin
                do_start = 1'b1;
                state_d  = WAIT_TX;
            end
            WAIT_TX: if (tx_seen && uart_tx_ready) begin
                tx_done = 1'b1;
                state_d = (word_cnt == LAST_WORD) ? RECV : SEND;
            end
            RECV: begin
                if (uart_rx_valid) begin
                    rx_take = 1'b1;
                    rx_done = (rx_cnt == LAST_WORD);
                end
                // A final byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_done) begin
                    state_d = IDLE;
                end else if (timer == TIMER_LAST) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift      <= '0;
            word_cnt      <= '0;
            rx_cnt        <= '0;
            timer         <= '0;
            tx_seen       <= 1'b0;
            rx_hist       <= '0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            rsp_valid     <= 1'b0;
            rsp_msg       <= '0;
            rsp_timeout   <= 1'b0;
            rx_stray      <= 1'b0;
`ifdef MSG_REQUESTER_CHECKSUM_EN
            rsp_error_q   <= 1'b0;
`endif
        end else begin
            uart_tx_start <= do_start;
            rsp_valid     <= rx_done;
            rsp_timeout   <= expire;
            rx_stray      <= uart_rx_valid && (state_q != RECV);

            if (accept) begin
                tx_shift <= tx_load;
                word_cnt <= '0;
            end else if (tx_done && word_cnt != LAST_WORD) begin
                tx_shift <= tx_shift << WORD_SIZE;
                word_cnt <= word_cnt + 1'b1;
            end

            // The UART must be seen busy once before its ready counts as "byte done".
            if (do_start) begin
                uart_tx_data <= tx_shift[TX_W-1 -: WORD_SIZE];
                tx_seen      <= 1'b0;
            end else if (state_q == WAIT_TX && !uart_tx_ready) begin
                tx_seen <= 1'b1;
            end

            if (tx_done && word_cnt == LAST_WORD) begin
                timer   <= '0;
                rx_cnt  <= '0;
                rx_hist <= '0;
            end else if (state_q == RECV) begin
                if (timer != TIMER_LAST) timer <= timer + 1'b1;
                if (rx_take) begin
                    rx_hist <= rx_next[TX_W-WORD_SIZE-1:0];
                    if (rx_cnt != LAST_WORD) rx_cnt <= rx_cnt + 1'b1;
                end
            end

            if (rx_done) rsp_msg <= rx_next[TX_W-1 -: MSG_W];
`ifdef MSG_REQUESTER_CHECKSUM_EN
            rsp_error_q <= rx_done &&
                           (rx_next[WORD_SIZE-1:0] != xor_words(rx_next[TX_W-1 -: MSG_W]));
`endif
        end
    end
endmodule
